// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage with one-entry decode hold buffer and branch flush
//
// Owns the fetch PC and issues one instruction-memory request at a time.
// Each returned word is presented with its PC in the IF/ID register.
// Decode back-pressure is absorbed by a one-entry hold buffer.
// A branch redirect flushes IF/ID and the buffer, and kills any in-flight response.
//
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   pc_o / pc_next_i               fetch PC to the external adder, pc_o + 4 back
//   branch_taken_i, branch_target_i
//                                  redirect pulse and target from execute
//   stall_i                        decode cannot accept a new IF/ID word
//   imem_req_o, imem_addr_o, imem_gnt_i
//                                  request channel; address always equals pc_o
//   imem_rvalid_i, imem_rdata_i    response channel, one pulse per granted request
//   if_valid_o, if_pc_o, if_instr_o
//                                  IF/ID pipeline register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_next_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic        kill_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  // The buffered word's PC is always pc_q: the PC does not advance while in HOLD.
  logic [31:0] hold_instr_q;
  logic        slot_free;

  assign slot_free = !stall_i || !if_valid_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      kill_q       <= 1'b0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= 32'h0;
      if_instr_q   <= 32'h0;
      hold_instr_q <= 32'h0;
    end else begin
      // Decode consumed the word; PC and instruction are left stale.
      if (!stall_i) begin
        if_valid_q <= 1'b0;
      end

      if (branch_taken_i) begin
        // Redirect wins over stall, rvalid and grant. Dropping the buffer is
        // implicit in leaving HOLD.
        if_valid_q <= 1'b0;
        pc_q       <= branch_target_i;
        case (state_q)
          S_REQ: begin
            if (imem_gnt_i) begin
              // The old-address request was accepted: its response must be dropped.
              state_q <= S_WAIT;
              kill_q  <= 1'b1;
              req_q   <= 1'b0;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rvalid_i) begin
              state_q <= S_REQ;
              kill_q  <= 1'b0;
              req_q   <= 1'b1;
            end else begin
              kill_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        endcase
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
          S_REQ: begin
            if (imem_gnt_i) begin
              state_q <= S_WAIT;
              req_q   <= 1'b0;
            end
          end
          S_WAIT: begin
            if (imem_rvalid_i) begin
              if (kill_q) begin
                // Stale response from before a redirect; pc_q already holds the target.
                kill_q  <= 1'b0;
                state_q <= S_REQ;
                req_q   <= 1'b1;
              end else if (slot_free) begin
                if_valid_q <= 1'b1;
                if_pc_q    <= pc_q;
                if_instr_q <= imem_rdata_i;
                pc_q       <= pc_next_i;
                state_q    <= S_REQ;
                req_q      <= 1'b1;
              end else begin
                hold_instr_q <= imem_rdata_i;
                state_q      <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!stall_i) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= pc_q;
              if_instr_q <= hold_instr_q;
              pc_q       <= pc_next_i;
              state_q    <= S_REQ;
              req_q      <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign pc_o        = pc_q;
  assign imem_addr_o = pc_q;
  assign imem_req_o  = req_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = if_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int NVEC = 27;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] pc_next;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic        stall = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        ifv;
  logic [31:0] ifpc;
  logic [31:0] ifinstr;

  always #5 clk = ~clk;

  // External PC adder.
  assign pc_next = pc_o + 32'd4;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .pc_o            (pc_o),
    .pc_next_i       (pc_next),
    .branch_taken_i  (br),
    .branch_target_i (tgt),
    .stall_i         (stall),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_gnt_i      (gnt),
    .imem_rvalid_i   (rv),
    .imem_rdata_i    (rdata),
    .if_valid_o      (ifv),
    .if_pc_o         (ifpc),
    .if_instr_o      (ifinstr)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rd_addr;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[NVEC];

  function automatic vec_t mk(input logic g, input logic r, input logic [31:0] ra,
                              input logic s, input logic b, input logic [31:0] t,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.gnt = g; v.rv = r; v.rd_addr = ra; v.stall = s; v.br = b; v.tgt = t;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  // Random-phase model state
  logic [31:0] exp_pc;
  logic        pending;
  logic [31:0] paddr;
  int          pdelay;
  int          delivered;
  logic        p_req, p_gnt, p_rv, p_br, p_stall, p_valid;
  logic [31:0] p_addr, p_tgt, p_ifpc;
  logic [31:0] rnd;

  initial begin
    //        gnt   rv    rd_addr      stall br    tgt          req   addr         valid pc
    tbl[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0);
    tbl[6]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0);
    tbl[7]  = mk(1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104);
    tbl[8]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h104);
    tbl[9]  = mk(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h104);
    tbl[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h104);
    tbl[11] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h108, 1'b1, 32'h104);
    tbl[12] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h108);
    tbl[13] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h10C, 1'b0, 32'h0);
    tbl[14] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b0, 32'h200, 1'b0, 32'h0);
    tbl[15] = mk(1'b0, 1'b1, 32'h10C, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0);
    tbl[16] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h200, 1'b0, 32'h0);
    tbl[17] = mk(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b1, 32'h200);
    tbl[18] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h300, 1'b0, 32'h300, 1'b0, 32'h0);
    tbl[19] = mk(1'b0, 1'b1, 32'h204, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0);
    tbl[20] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h300, 1'b0, 32'h0);
    tbl[21] = mk(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   1'b1, 32'h304, 1'b1, 32'h300);
    tbl[22] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h304, 1'b1, 32'h300);
    tbl[23] = mk(1'b0, 1'b1, 32'h304, 1'b1, 1'b0, 32'h0,   1'b0, 32'h304, 1'b1, 32'h300);
    tbl[24] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h400, 1'b1, 32'h400, 1'b0, 32'h0);
    tbl[25] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h400, 1'b0, 32'h0);
    tbl[26] = mk(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0,   1'b1, 32'h404, 1'b1, 32'h400);

    // Reset state
    #12;
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_req", 32'(req), 32'h0);
    chk("rst_valid", 32'(ifv), 32'h0);
    chk("rst_if_pc", ifpc, 32'h0);
    chk("rst_if_instr", ifinstr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      gnt   = tbl[i].gnt;
      rv    = tbl[i].rv;
      rdata = tbl[i].rv ? mem_word(tbl[i].rd_addr) : 32'hDEAD_BEEF;
      stall = tbl[i].stall;
      br    = tbl[i].br;
      tgt   = tbl[i].tgt;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_req", i), 32'(req), 32'(tbl[i].exp_req));
      chk($sformatf("v%0d_addr", i), addr, tbl[i].exp_addr);
      chk($sformatf("v%0d_pc_eq_addr", i), pc_o, addr);
      chk($sformatf("v%0d_valid", i), 32'(ifv), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("v%0d_if_pc", i), ifpc, tbl[i].exp_pc);
        chk($sformatf("v%0d_if_instr", i), ifinstr, mem_word(tbl[i].exp_pc));
      end
    end

    // Asynchronous reset in the middle of WAIT
    gnt = 1'b1; rv = 1'b0; stall = 1'b0; br = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_o, RST_PC);
    chk("arst_req", 32'(req), 32'h0);
    chk("arst_valid", 32'(ifv), 32'h0);
    chk("arst_if_pc", ifpc, 32'h0);
    chk("arst_if_instr", ifinstr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    gnt   = 1'b0;
    rv    = 1'b1;
    rdata = mem_word(32'h404);
    @(posedge clk);
    @(negedge clk);
    rv = 1'b0;
    chk("stray_rvalid_valid", 32'(ifv), 32'h0);
    chk("stray_rvalid_req", 32'(req), 32'h1);
    chk("stray_rvalid_addr", addr, RST_PC);

    // Randomized phase against a transaction-level model
    exp_pc = RST_PC; pending = 1'b0; paddr = 32'h0; pdelay = 0; delivered = 0;
    p_br = 1'b0; p_tgt = 32'h0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rv = pending && (pdelay == 0);
      if (pending && pdelay > 0) pdelay--;
      rdata = rv ? mem_word(paddr) : $urandom;
      gnt   = ($urandom % 2) == 0;
      stall = ($urandom % 10) < 3;
      br    = !p_br && (($urandom % 16) == 0);
      rnd   = $urandom;
      tgt   = rnd & 32'hFFFF_FFFC;

      p_req = req; p_addr = addr; p_gnt = gnt; p_rv = rv; p_br = br; p_tgt = tgt;
      p_stall = stall; p_valid = ifv; p_ifpc = ifpc;

      @(posedge clk);
      @(negedge clk);

      chk("rnd_addr_eq_pc", addr, pc_o);
      if (p_br) begin
        chk("rnd_flush_valid", 32'(ifv), 32'h0);
        chk("rnd_redirect_addr", addr, p_tgt);
        exp_pc = p_tgt;
      end else if (p_valid && p_stall) begin
        chk("rnd_hold_valid", 32'(ifv), 32'h1);
        chk("rnd_hold_pc", ifpc, p_ifpc);
      end else if (ifv) begin
        chk("rnd_if_pc", ifpc, exp_pc);
        chk("rnd_if_instr", ifinstr, mem_word(ifpc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end

      if (p_rv) pending = 1'b0;
      if (p_req && p_gnt) begin
        chk("rnd_one_outstanding", 32'(pending), 32'h0);
        pending = 1'b1;
        paddr   = p_addr;
        pdelay  = $urandom_range(0, 3);
      end
      if (pending) chk("rnd_no_req_while_outstanding", 32'(req), 32'h0);
    end
    chk("rnd_progress", 32'(delivered > 300), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the single-issue CPU pipeline. It owns the architectural fetch PC, feeds it to the PC adder, and receives `pc + 4` back. It issues one instruction-memory request at a time and presents each fetched instruction with its PC in the IF/ID pipeline register. It also handles decode stalls through a one-entry hold buffer and flushes on branch redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.

- `clk_i` in 1: clock; all state updates on posedge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `pc_o` out 32: current fetch PC, driven to the PC adder input.
- `pc_next_i` in 32: sequential next PC (`pc_o + 4`) from the PC adder. Must be valid no later than 1 cycle after `pc_o` changes.
- `branch_taken_i` in 1: redirect request from execute; single-cycle pulse.
- `branch_target_i` in 32: redirect address, valid while `branch_taken_i`=1.
- `stall_i` in 1: decode cannot accept a new IF/ID word this cycle.
- `imem_req_o` out 1: request valid.
- `imem_addr_o` out 32: request address; always equals `pc_o`.
- `imem_gnt_i` in 1: memory accepts the request this cycle.
- `imem_rvalid_i` in 1: read data valid; single-cycle pulse, ≥1 cycle after the grant.
- `imem_rdata_i` in 32: instruction word.
- `if_valid_o` out 1: IF/ID register holds a valid instruction.
- `if_pc_o` out 32: PC of the IF/ID instruction.
- `if_instr_o` out 32: IF/ID instruction.

## Operation
- Reset values:
  - `pc_o`=`RESET_PC`, `imem_req_o`=0.
  - `if_valid_o`=0, `if_pc_o`=0, `if_instr_o`=0.
  - hold buffer empty, kill flag=0, state IDLE.
- FSM states: IDLE, REQ, WAIT, HOLD.
- `imem_req_o`=1 only in REQ. Memory samples `imem_addr_o` only on a cycle with req&&gnt. The address may change while req&&!gnt.
- IDLE → REQ unconditionally on the next cycle.
- REQ:
  - gnt=1 → WAIT.
  - gnt=0 → stay in REQ.
- WAIT, on `imem_rvalid_i`:
  - kill flag=1 → discard data, clear kill, go to REQ; `pc_o` was already redirected.
  - IF/ID slot free (`stall_i`=0 or `if_valid_o`=0) → load IF/ID with {1, `pc_o`, `imem_rdata_i`}; `pc_o` ← `pc_next_i`; go to REQ.
  - Otherwise → capture {`pc_o`, data} in the hold buffer and go to HOLD.
- HOLD: when `stall_i`=0, move the buffer into IF/ID, `pc_o` ← `pc_next_i`, go to REQ.
- IF/ID with no new load:
  - `stall_i`=1 → contents held.
  - `stall_i`=0 → `if_valid_o` ← 0. `if_pc_o` and `if_instr_o` keep stale values.
- Redirect (`branch_taken_i`=1) has highest priority, overriding stall, rvalid and grant:
  - `if_valid_o` ← 0, hold buffer dropped, `pc_o` ← `branch_target_i`.
  - In REQ with gnt=0: stay in REQ; the new address is presented next cycle.
  - In REQ with gnt=1: the old-address request is in flight. Go to WAIT with kill=1.
  - In WAIT without rvalid: kill ← 1, stay in WAIT.
  - In WAIT with rvalid: discard data, go to REQ, kill=0.
  - In HOLD: go to REQ.
  - In IDLE: go to REQ.
- At most one outstanding memory transaction.
- All PC arithmetic is external. The block performs no alignment check and passes `branch_target_i` through unmodified.

## Timing
- First `imem_req_o`: 2nd rising edge after `rst_n_i` deasserts (IDLE then REQ).
- `pc_next_i` is sampled only when leaving WAIT or HOLD. This is ≥2 cycles after the last `pc_o` update, which covers the PC adder's 1-cycle registered latency.
- Best-case throughput is 1 instruction per 2 cycles:
  - REQ with same-cycle gnt;
  - WAIT with rvalid on the next cycle;
  - IF/ID updates at the edge ending WAIT.
- Redirect-to-request latency: the new address appears on `imem_addr_o` the cycle after `branch_taken_i`.
- Flush is visible as `if_valid_o`=0 the cycle after `branch_taken_i`.
- Async reset mid-transaction:
  - all state clears immediately;
  - any later `imem_rvalid_i` for the aborted request is ignored (state not WAIT);
  - the memory side must also be reset.

## Test plan
- Reset release, `RESET_PC`=0x100, gnt always 1, rvalid 1 cycle after gnt, `pc_next_i`=`pc_o`+4 → `if_pc_o` sequence 0x100, 0x104, 0x108 with instructions updating every 2 cycles; first req on the 2nd edge after reset release.
- Hold gnt=0 for 3 cycles in REQ → `imem_req_o` stays 1 and `imem_addr_o` stable at 0x104; fetch completes normally after the grant.
- `stall_i`=1 for 4 cycles with IF/ID valid (0x104) while rvalid returns 0x108 → IF/ID holds 0x104 and FSM is in HOLD. On stall release, IF/ID=0x108 and the next req is to 0x10C.
- `branch_taken_i` with target 0x200 during WAIT → `if_valid_o`=0 next cycle, the returning word is discarded, next req addr is 0x200, and the next valid `if_pc_o`=0x200.
- `branch_taken_i` (target 0x300) on the same cycle as gnt in REQ → old response discarded, req to 0x300 follows. Branch plus `stall_i`=1 in HOLD → buffer dropped, `if_valid_o`=0.
- Assert `rst_n_i`=0 asynchronously mid-WAIT → all outputs at reset values before the next clock edge. A stray rvalid afterwards does not set `if_valid_o`.
